// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronizer, per-channel debounce, press/release
// pulses and auto-repeat press pulses on masked channels.
module button_conditioner #(
  parameter int                     NUM_BUTTONS         = 6,
  parameter int                     DEBOUNCE_CYCLES     = 2500000,
  parameter int                     REPEAT_DELAY_CYCLES = 62500000,
  parameter int                     REPEAT_RATE_CYCLES  = 12500000,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK         = 6'b011000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BUTTONS-1:0]     btn_raw,
  output logic [NUM_BUTTONS-1:0]     btn_level,
  output logic [NUM_BUTTONS-1:0]     btn_press,
  output logic [NUM_BUTTONS-1:0]     btn_release,
  output logic [2*NUM_BUTTONS-1:0]   dbg_state_o
);

  localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW      = $clog2(RPT_MAX + 1);

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0]  RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [RW-1:0]  rpt_cnt_q;
    logic           level_q, press_q, release_q;
    logic           mismatch, db_done;
    state_e         state_q;

    assign mismatch = sync2_q[i] ^ level_q;
    assign db_done  = mismatch && (db_cnt_q == DB_LAST);

    always_comb begin
      db_cnt_d = db_cnt_q + DBW'(1);
      if (!mismatch || db_done) db_cnt_d = '0;
    end

    // A debounced edge always wins over a repeat pulse due in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        db_cnt_q  <= '0;
        rpt_cnt_q <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        state_q   <= ST_IDLE;
      end else begin
        db_cnt_q  <= db_cnt_d;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (db_done) level_q <= ~level_q;
        case (state_q)
          ST_IDLE: begin
            if (db_done) begin
              state_q   <= ST_HELD;
              press_q   <= 1'b1;
              rpt_cnt_q <= '0;
            end
          end
          ST_HELD: begin
            if (db_done) begin
              state_q   <= ST_IDLE;
              release_q <= 1'b1;
              rpt_cnt_q <= '0;
            end else if (REPEAT_MASK[i]) begin
              if (rpt_cnt_q == DELAY_LAST) begin
                state_q   <= ST_REPEAT;
                press_q   <= 1'b1;
                rpt_cnt_q <= '0;
              end else begin
                rpt_cnt_q <= rpt_cnt_q + RW'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (db_done) begin
              state_q   <= ST_IDLE;
              release_q <= 1'b1;
              rpt_cnt_q <= '0;
            end else if (rpt_cnt_q == RATE_LAST) begin
              press_q   <= 1'b1;
              rpt_cnt_q <= '0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RW'(1);
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]          = level_q;
    assign btn_press[i]          = press_q;
    assign btn_release[i]        = release_q;
    assign dbg_state_o[2*i +: 2] = state_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulse events are queued by the
// stimulus and popped by a negedge monitor whenever a pulse appears.
module tb_button_conditioner;

  localparam int N = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   btn_raw;
  logic [N-1:0]   btn_level, btn_press, btn_release;
  logic [2*N-1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Event word: {cycle[31:0], press[5:0], release[5:0], level[5:0]}
  logic [49:0]  exp_q[$];
  logic [49:0]  exp_w, obs_w;
  logic [N-1:0] exp_level = '0;

  button_conditioner #(
    .NUM_BUTTONS(N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_RATE_CYCLES(3),
    .REPEAT_MASK(6'b011000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input logic [N-1:0] p, input logic [N-1:0] r,
                         input logic [N-1:0] l);
    exp_q.push_back({32'(c), p, r, l});
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (btn_level !== '0 || btn_press !== '0 || btn_release !== '0 || dbg_state !== '0) begin
      failures++;
      $display("FAIL %s got level=%b press=%b release=%b state=%h want all zero",
               name, btn_level, btn_press, btn_release, dbg_state);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      exp_level = '0;
      checks++;
      if (btn_level !== '0 || btn_press !== '0 || btn_release !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got level=%b press=%b release=%b want 0",
                 cyc, btn_level, btn_press, btn_release);
      end
    end else if (|btn_press || |btn_release) begin
      checks++;
      obs_w = {32'(cyc), btn_press, btn_release, btn_level};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d got press=%b release=%b level=%b want none",
                 cyc, btn_press, btn_release, btn_level);
      end else begin
        exp_w = exp_q.pop_front();
        if (obs_w !== exp_w) begin
          failures++;
          $display("FAIL event got cyc=%0d p=%b r=%b l=%b want cyc=%0d p=%b r=%b l=%b",
                   obs_w[49:18], obs_w[17:12], obs_w[11:6], obs_w[5:0],
                   exp_w[49:18], exp_w[17:12], exp_w[11:6], exp_w[5:0]);
        end
        exp_level = exp_w[5:0];
      end
    end else begin
      checks++;
      if (btn_level !== exp_level) begin
        failures++;
        $display("FAIL level_hold cyc=%0d got level=%b want %b", cyc, btn_level, exp_level);
      end
    end
  end

  initial begin : stim
    int k, f, g, r;
    int rep3_offs[10];
    rep3_offs = '{16, 19, 22, 25, 28, 31, 34, 37, 40, 43};

    reset   = 1'b0;
    btn_raw = '0;
    #2;
    check_zero("reset_initial");
    tick(3);
    check_zero("reset_held");
    reset = 1'b1;
    tick(3);

    // Clean press and release on changeLight (unmasked: single press only).
    btn_raw[2] = 1'b1;
    k = cyc;
    push_ev(k + 6, 6'b000100, 6'b000000, 6'b000100);
    tick(20);
    btn_raw[2] = 1'b0;
    g = cyc;
    push_ev(g + 6, 6'b000000, 6'b000100, 6'b000000);
    tick(10);

    // Bounce on confirm: 3 high, 1 low, 2 high, 2 low, then stable high.
    btn_raw[5] = 1'b1; tick(3);
    btn_raw[5] = 1'b0; tick(1);
    btn_raw[5] = 1'b1; tick(2);
    btn_raw[5] = 1'b0; tick(2);
    btn_raw[5] = 1'b1;
    f = cyc;
    push_ev(f + 6, 6'b100000, 6'b000000, 6'b100000);
    tick(14);
    btn_raw[5] = 1'b0;
    g = cyc;
    push_ev(g + 6, 6'b000000, 6'b100000, 6'b000000);
    tick(10);

    // Auto-repeat on increaseTime; the repeat due at k+46 coincides with release.
    btn_raw[3] = 1'b1;
    k = cyc;
    push_ev(k + 6, 6'b001000, 6'b000000, 6'b001000);
    for (int i = 0; i < 10; i++)
      push_ev(k + rep3_offs[i], 6'b001000, 6'b000000, 6'b001000);
    push_ev(k + 46, 6'b000000, 6'b001000, 6'b000000);
    tick(40);
    btn_raw[3] = 1'b0;
    tick(14);

    // Simultaneous press and release on changeMode and config.
    btn_raw[1:0] = 2'b11;
    k = cyc;
    push_ev(k + 6, 6'b000011, 6'b000000, 6'b000011);
    tick(18);
    btn_raw[1:0] = 2'b00;
    g = cyc;
    push_ev(g + 6, 6'b000000, 6'b000011, 6'b000000);
    tick(10);

    // Reset in the middle of a decreaseTime repeat sequence, button held through.
    btn_raw[4] = 1'b1;
    k = cyc;
    push_ev(k + 6,  6'b010000, 6'b000000, 6'b010000);
    push_ev(k + 16, 6'b010000, 6'b000000, 6'b010000);
    push_ev(k + 19, 6'b010000, 6'b000000, 6'b010000);
    tick(20);
    #1 reset = 1'b0;
    #1 check_zero("midop_reset_immediate");
    tick(3);
    check_zero("midop_reset_held");
    reset = 1'b1;
    r = cyc;
    push_ev(r + 6,  6'b010000, 6'b000000, 6'b010000);
    push_ev(r + 16, 6'b010000, 6'b000000, 6'b010000);
    push_ev(r + 19, 6'b010000, 6'b000000, 6'b010000);
    push_ev(r + 22, 6'b010000, 6'b000000, 6'b010000);
    push_ev(r + 25, 6'b010000, 6'b000000, 6'b010000);
    push_ev(r + 26, 6'b000000, 6'b010000, 6'b000000);
    tick(20);
    btn_raw[4] = 1'b0;
    tick(14);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got %0d pending want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
